// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants and the window byte-ordering helper for inst_prefetch_queue.
// The optional PREFETCH_PERF_EN build adds no package content.
package inst_prefetch_queue_pkg;

    localparam int IPQ_WIN_BYTES = 6;
    localparam int IPQ_CONSUME_W = 3;
    localparam int IPQ_WIN_W     = IPQ_WIN_BYTES * 8;

    // Window byte idx occupies bits [lsb +: 8]; byte 0 is the queue head.
    function automatic int ipq_win_lsb(input int idx);
        return idx * 8;
    endfunction

endpackage

// File: rtl/ipq_perf_counters.sv
// Saturating 32-bit event counters for the prefetch queue.
// Instantiated only when PREFETCH_PERF_EN is defined.
module ipq_perf_counters (
    input  logic        clock,
    input  logic        resetn,
    input  logic        starve_i,
    input  logic        full_i,
    input  logic        flush_i,
    output logic [31:0] perf_starve,
    output logic [31:0] perf_full,
    output logic [31:0] perf_flush
);

    logic [31:0] starve_q, full_q, flush_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            starve_q <= '0;
            full_q   <= '0;
            flush_q  <= '0;
        end else begin
            starve_q <= sat_inc(starve_q, starve_i);
            full_q   <= sat_inc(full_q, full_i);
            flush_q  <= sat_inc(flush_q, flush_i);
        end
    end

    assign perf_starve = starve_q;
    assign perf_full   = full_q;
    assign perf_flush  = flush_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Byte-wide instruction prefetch queue presenting the oldest 6 bytes as a window.
// Define PREFETCH_PERF_EN to add the starve/full/flush performance counters.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clock,
    input  logic                     resetn,
    output logic [31:0]              instmem_addr,
    input  logic [7:0]               instmem_dataout,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic [IPQ_CONSUME_W-1:0] consume,
    output logic [IPQ_WIN_W-1:0]     q_window,
    output logic [3:0]               q_count,
    output logic [31:0]              q_head_pc
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]              perf_starve,
    output logic [31:0]              perf_full,
    output logic [31:0]              perf_flush
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
    logic [CW-1:0] n_take;
    logic          fill;

    // Fill looks only at the registered count, so consume never reaches the memory port.
    assign fill = (count_q < CW'(DEPTH)) && !redirect;

    always_comb begin
        n_take = CW'(consume);
        if (n_take > count_q)               n_take = count_q;
        if (n_take > CW'(IPQ_WIN_BYTES))    n_take = CW'(IPQ_WIN_BYTES);
    end

    // NOTE: every next-state signal gets its value on every path, so no latch is inferred.
    always_comb begin
        rd_ptr_d   = rd_ptr_q + PW'(n_take);
        head_pc_d  = head_pc_q + 32'(n_take);
        wr_ptr_d   = wr_ptr_q + PW'(fill);
        fetch_pc_d = fetch_pc_q + 32'(fill);
        count_d    = count_q + CW'(fill) - n_take;
        if (redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
            head_pc_d  = redirect_pc;
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together on the edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
        end
    end

    // NOTE: the byte storage has no reset; slots beyond count are masked in the window.
    always_ff @(posedge clock) begin
        if (fill) mem_q[wr_ptr_q] <= instmem_dataout;
    end

    always_comb begin
        q_window = '0;
        for (int i = 0; i < IPQ_WIN_BYTES; i++) begin
            if (CW'(i) < count_q)
                q_window[ipq_win_lsb(i) +: 8] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

    assign instmem_addr = fetch_pc_q;
    assign q_head_pc    = head_pc_q;
    assign q_count      = 4'(count_q);

`ifdef PREFETCH_PERF_EN
    ipq_perf_counters u_perf (
        .clock       (clock),
        .resetn      (resetn),
        .starve_i    ((count_q == '0) && !redirect),
        .full_i      (count_q == CW'(DEPTH)),
        .flush_i     (redirect),
        .perf_starve (perf_starve),
        .perf_full   (perf_full),
        .perf_flush  (perf_flush)
    );
`endif

endmodule
